// File: rtl/mem_arbiter_if.sv
// Bus bundle tying two requesters and the single-port memory to mem_arbiter.
// The master side is the environment (requesters plus memory); the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int W = 7,
    parameter int A = 4
);
    logic         r0_req;
    logic         r1_req;
    logic         r0_wrt_read;
    logic         r1_wrt_read;
    logic [A-1:0] r0_add;
    logic [A-1:0] r1_add;
    logic [W-1:0] r0_write;
    logic [W-1:0] r1_write;
    logic         r0_gnt;
    logic         r1_gnt;
    logic         r0_rvalid;
    logic         r1_rvalid;
    logic [W-1:0] r0_rdata;
    logic [W-1:0] r1_rdata;
    logic         mem_enable;
    logic         mem_wrt_read;
    logic [A-1:0] mem_add;
    logic [W-1:0] mem_write;
    logic [W-1:0] mem_out;

    modport master (
        output r0_req, r1_req, r0_wrt_read, r1_wrt_read,
        output r0_add, r1_add, r0_write, r1_write,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
        input  mem_enable, mem_wrt_read, mem_add, mem_write,
        output mem_out
    );

    modport slave (
        input  r0_req, r1_req, r0_wrt_read, r1_wrt_read,
        input  r0_add, r1_add, r0_write, r1_write,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
        output mem_enable, mem_wrt_read, mem_add, mem_write,
        input  mem_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and command sequencer sharing one single-port memory between two requesters.
// Out-of-range addresses are granted but never enable the memory; such reads return zero.
module mem_arbiter #(
    parameter int          W = 7,
    parameter int unsigned L = 10,
    parameter int          A = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;

    state_e       state_q;
    logic         lastGnt_q;
    logic         cmdWr_q;
    logic         cmdInRange_q;
    logic         r0Gnt_q;
    logic         r1Gnt_q;
    logic         r0Rvalid_q;
    logic         r1Rvalid_q;
    logic [W-1:0] r0Rdata_q;
    logic [W-1:0] r1Rdata_q;
    logic         memEnable_q;
    logic         memWrtRead_q;
    logic [A-1:0] memAdd_q;
    logic [W-1:0] memWrite_q;

    logic         anyReq;
    logic         winner_d;
    logic         selWr_d;
    logic         selInRange_d;
    logic [A-1:0] selAdd_d;
    logic [W-1:0] selData_d;
    logic [W-1:0] respData;

    assign anyReq   = bus_io.r0_req | bus_io.r1_req;
    assign respData = cmdInRange_q ? bus_io.mem_out : '0;

    // On a tie the requester not granted last wins; a lone request always wins.
    always_comb begin
        winner_d = bus_io.r1_req;
        if (bus_io.r0_req && bus_io.r1_req) begin
            winner_d = ~lastGnt_q;
        end
        selWr_d      = winner_d ? bus_io.r1_wrt_read : bus_io.r0_wrt_read;
        selAdd_d     = winner_d ? bus_io.r1_add      : bus_io.r0_add;
        selData_d    = winner_d ? bus_io.r1_write    : bus_io.r0_write;
        selInRange_d = 32'(selAdd_d) < 32'(L);
    end

    // The mem_* registers double as the command registers; lastGnt_q names the
    // owner of the transaction in flight, so RESP routes read data with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            lastGnt_q    <= 1'b1;
            cmdWr_q      <= 1'b0;
            cmdInRange_q <= 1'b0;
            r0Gnt_q      <= 1'b0;
            r1Gnt_q      <= 1'b0;
            r0Rvalid_q   <= 1'b0;
            r1Rvalid_q   <= 1'b0;
            r0Rdata_q    <= '0;
            r1Rdata_q    <= '0;
            memEnable_q  <= 1'b0;
            memWrtRead_q <= 1'b0;
            memAdd_q     <= '0;
            memWrite_q   <= '0;
        end else begin
            r0Gnt_q      <= 1'b0;
            r1Gnt_q      <= 1'b0;
            r0Rvalid_q   <= 1'b0;
            r1Rvalid_q   <= 1'b0;
            memEnable_q  <= 1'b0;
            memWrtRead_q <= 1'b0;
            memAdd_q     <= '0;
            memWrite_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        lastGnt_q    <= winner_d;
                        cmdWr_q      <= selWr_d;
                        cmdInRange_q <= selInRange_d;
                        r0Gnt_q      <= ~winner_d;
                        r1Gnt_q      <= winner_d;
                        memEnable_q  <= selInRange_d;
                        memWrtRead_q <= selWr_d;
                        memAdd_q     <= selAdd_d;
                        memWrite_q   <= selData_d;
                        state_q      <= CMD;
                    end
                end
                CMD: begin
                    state_q <= cmdWr_q ? IDLE : RESP;
                end
                RESP: begin
                    if (lastGnt_q) begin
                        r1Rdata_q  <= respData;
                        r1Rvalid_q <= 1'b1;
                    end else begin
                        r0Rdata_q  <= respData;
                        r0Rvalid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.r0_gnt       = r0Gnt_q;
    assign bus_io.r1_gnt       = r1Gnt_q;
    assign bus_io.r0_rvalid    = r0Rvalid_q;
    assign bus_io.r1_rvalid    = r1Rvalid_q;
    assign bus_io.r0_rdata     = r0Rdata_q;
    assign bus_io.r1_rdata     = r1Rdata_q;
    assign bus_io.mem_enable   = memEnable_q;
    assign bus_io.mem_wrt_read = memWrtRead_q;
    assign bus_io.mem_add      = memAdd_q;
    assign bus_io.mem_write    = memWrite_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus predicts grant/rvalid events into a queue,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_mem_arbiter;
    localparam int W = 7;
    localparam int L = 10;
    localparam int A = 4;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if #(.W(W), .A(A)) bus ();

    mem_arbiter #(.W(W), .L(L), .A(A)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nextArb  = 0;
    bit lastGnt  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           isRv;
        bit           who;
        int           at;
        bit           en;
        bit           wr;
        logic [A-1:0] add;
        logic [W-1:0] data;
    } exp_t;

    exp_t expQ[$];

    logic [W-1:0] memArr[L] = '{default: '0};
    logic [W-1:0] refMem[L] = '{default: '0};

    // Behavioural single-port memory sharing the arbiter's reset
    always @(posedge clk) begin
        if (!reset) begin
            bus.mem_out <= '0;
        end else if (bus.mem_enable && (32'(bus.mem_add) < L)) begin
            if (bus.mem_wrt_read) memArr[bus.mem_add] <= bus.mem_write;
            else                  bus.mem_out <= memArr[bus.mem_add];
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic matchEvent(input bit isRv, input bit who);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput(isRv ? "unexpected_rvalid" : "unexpected_gnt", int'(who), -1);
            return;
        end
        e = expQ.pop_front();
        checkOutput("event_kind", int'(isRv), int'(e.isRv));
        checkOutput("event_requester", int'(who), int'(e.who));
        checkOutput("event_cycle", cyc, e.at);
        if (!isRv) begin
            checkOutput("mem_enable", int'(bus.mem_enable), int'(e.en));
            checkOutput("mem_wrt_read", int'(bus.mem_wrt_read), int'(e.wr));
            checkOutput("mem_add", int'(bus.mem_add), int'(e.add));
            checkOutput("mem_write", int'(bus.mem_write), int'(e.data));
        end else begin
            checkOutput(who ? "r1_rdata" : "r0_rdata",
                        int'(who ? bus.r1_rdata : bus.r0_rdata), int'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (bus.r0_gnt === 1'b1)    matchEvent(1'b0, 1'b0);
        if (bus.r1_gnt === 1'b1)    matchEvent(1'b0, 1'b1);
        if (bus.r0_rvalid === 1'b1) matchEvent(1'b1, 1'b0);
        if (bus.r1_rvalid === 1'b1) matchEvent(1'b1, 1'b1);
        if (bus.mem_enable === 1'b1 && bus.r0_gnt !== 1'b1 && bus.r1_gnt !== 1'b1)
            checkOutput("mem_enable_without_gnt", 1, 0);
    end

    // Reference model: a grant at cycle t costs 2 cycles for a write, 3 for a read
    task automatic modelGrant(input bit who, input bit wr, input logic [A-1:0] add,
                              input logic [W-1:0] data, inout int t);
        exp_t e;
        bit   inR;
        inR    = 32'(add) < L;
        e.isRv = 1'b0;
        e.who  = who;
        e.at   = t;
        e.en   = inR;
        e.wr   = wr;
        e.add  = add;
        e.data = data;
        expQ.push_back(e);
        lastGnt = who;
        if (wr) begin
            if (inR) refMem[add] = data;
            t += 2;
        end else begin
            e.isRv = 1'b1;
            e.at   = t + 2;
            e.data = inR ? refMem[add] : '0;
            expQ.push_back(e);
            t += 3;
        end
    endtask

    task automatic applyStimulus(input bit u0, input bit w0, input logic [A-1:0] a0,
                                 input logic [W-1:0] d0, input bit u1, input bit w1,
                                 input logic [A-1:0] a1, input logic [W-1:0] d1, input int gap);
        bit order[2];
        int n;
        int t;
        int target;
        int budget;
        bit done0, done1, drop0, drop1;
        target = ((cyc > nextArb - 1) ? cyc : nextArb - 1) + gap;
        while (cyc < target) tick();
        if (u0 && u1) begin
            order[0] = lastGnt ? 1'b0 : 1'b1;
            order[1] = ~order[0];
            n = 2;
        end else begin
            order[0] = u1;
            order[1] = 1'b0;
            n = 1;
        end
        t = cyc + 1;
        for (int i = 0; i < n; i++) begin
            if (order[i]) modelGrant(1'b1, w1, a1, d1, t);
            else          modelGrant(1'b0, w0, a0, d0, t);
        end
        nextArb = t;
        if (u0) begin
            bus.r0_wrt_read = w0; bus.r0_add = a0; bus.r0_write = d0; bus.r0_req = 1'b1;
        end
        if (u1) begin
            bus.r1_wrt_read = w1; bus.r1_add = a1; bus.r1_write = d1; bus.r1_req = 1'b1;
        end
        done0 = !u0; done1 = !u1; drop0 = 1'b0; drop1 = 1'b0; budget = 0;
        while (!(done0 && done1) && budget < 20) begin
            tick();
            budget++;
            if (drop0) begin bus.r0_req = 1'b0; done0 = 1'b1; drop0 = 1'b0; end
            if (drop1) begin bus.r1_req = 1'b0; done1 = 1'b1; drop1 = 1'b0; end
            if (!done0 && bus.r0_gnt === 1'b1) drop0 = 1'b1;
            if (!done1 && bus.r1_gnt === 1'b1) drop1 = 1'b1;
        end
        if (!(done0 && done1)) begin
            checkOutput("grant_timeout", 0, 1);
            bus.r0_req = 1'b0;
            bus.r1_req = 1'b0;
        end
    endtask

    task automatic checkAllZero(input string prefix);
        checkOutput({prefix, "_r0_gnt"}, int'(bus.r0_gnt), 0);
        checkOutput({prefix, "_r1_gnt"}, int'(bus.r1_gnt), 0);
        checkOutput({prefix, "_r0_rvalid"}, int'(bus.r0_rvalid), 0);
        checkOutput({prefix, "_r1_rvalid"}, int'(bus.r1_rvalid), 0);
        checkOutput({prefix, "_r0_rdata"}, int'(bus.r0_rdata), 0);
        checkOutput({prefix, "_r1_rdata"}, int'(bus.r1_rdata), 0);
        checkOutput({prefix, "_mem_enable"}, int'(bus.mem_enable), 0);
        checkOutput({prefix, "_mem_wrt_read"}, int'(bus.mem_wrt_read), 0);
        checkOutput({prefix, "_mem_add"}, int'(bus.mem_add), 0);
        checkOutput({prefix, "_mem_write"}, int'(bus.mem_write), 0);
    endtask

    // r0 read of add 3 is cut off by reset while in RESP: only its grant is expected
    task automatic resetMidRead();
        exp_t e;
        int   target;
        target = (cyc > nextArb - 1) ? cyc : nextArb - 1;
        while (cyc < target) tick();
        e.isRv = 1'b0; e.who = 1'b0; e.at = cyc + 1; e.en = 1'b1;
        e.wr = 1'b0; e.add = 4'd3; e.data = '0;
        expQ.push_back(e);
        bus.r0_wrt_read = 1'b0; bus.r0_add = 4'd3; bus.r0_write = '0; bus.r0_req = 1'b1;
        tick();
        tick();
        bus.r0_req = 1'b0;
        reset = 1'b0;
        tick();
        checkAllZero("reset_mid_read");
        reset   = 1'b1;
        lastGnt = 1'b1;
        nextArb = cyc + 1;
    endtask

    initial begin
        int sel;
        bit u0, u1, w0, w1;
        logic [A-1:0] a0, a1;
        logic [W-1:0] d0, d1;
        reset = 1'b0;
        bus.r0_req = 1'b1; bus.r0_wrt_read = 1'b1; bus.r0_add = 4'd1; bus.r0_write = 7'd9;
        bus.r1_req = 1'b1; bus.r1_wrt_read = 1'b0; bus.r1_add = 4'd2; bus.r1_write = 7'd4;
        tick();
        checkAllZero("reset_c1");
        tick();
        checkAllZero("reset_c2");
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        reset      = 1'b1;
        lastGnt    = 1'b1;
        nextArb    = cyc + 1;
        $display("[TB] reset released at cycle %0d", cyc);

        applyStimulus(1, 1, 4'd3, 7'd33, 1, 1, 4'd5, 7'd66, 0);
        applyStimulus(1, 1, 4'd0, 7'd10, 0, 0, 4'd0, 7'd0, 0);
        applyStimulus(1, 0, 4'd0, 7'd0, 0, 0, 4'd0, 7'd0, 0);
        applyStimulus(1, 0, 4'd3, 7'd0, 0, 0, 4'd0, 7'd0, 1);
        applyStimulus(0, 0, 4'd0, 7'd0, 1, 0, 4'd5, 7'd0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'd1, 7'd0, 1, 0, 4'd1, 7'd0, 0);
        applyStimulus(1, 1, 4'd2, 7'd44, 0, 0, 4'd0, 7'd0, 0);
        applyStimulus(0, 0, 4'd0, 7'd0, 1, 1, 4'd12, 7'd5, 0);
        applyStimulus(0, 0, 4'd0, 7'd0, 1, 0, 4'd12, 7'd0, 0);
        applyStimulus(1, 0, 4'd2, 7'd0, 0, 0, 4'd0, 7'd0, 0);
        resetMidRead();
        applyStimulus(0, 0, 4'd0, 7'd0, 1, 0, 4'd5, 7'd0, 0);
        $display("[TB] directed phase done at cycle %0d", cyc);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(1, 3);
            u0  = sel[0];
            u1  = sel[1];
            w0  = 1'($urandom_range(0, 1));
            w1  = 1'($urandom_range(0, 1));
            a0  = A'($urandom_range(0, 15));
            a1  = A'($urandom_range(0, 15));
            d0  = W'($urandom);
            d1  = W'($urandom);
            applyStimulus(u0, w0, a0, d0, u1, w1, a1, d1, $urandom_range(0, 2));
        end

        repeat (6) tick();
        checkOutput("pending_events", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end
endmodule
